// File: rtl/geig_stack_serializer.sv
// Purpose: resynchronise a Geiger stack word, vet it, buffer one pending stack and emit it as a SYNC + 10-byte + XOR-checksum frame.
// Latency: SYNC_BYTE valid 4 cycles after G_DATA_STACK settles (2 sync stages, change detect, IDLE load); back-to-back frames need only one IDLE cycle.
// Backpressure: valid/ready byte stream; TX_DATA/TX_VALID held while TX_READY is low; stacks arriving mid-frame overwrite the single pending slot.
module geig_stack_serializer #(
    parameter logic [7:0]  SYNC_BYTE = 8'h7E,
    parameter logic [7:0]  GEIG_ID   = 8'h47,
    parameter logic [31:0] FILLER    = 32'hAAAAAAAA
) (
    input  logic        CLK_100KHZ,
    input  logic        RESET,
    input  logic [79:0] G_DATA_STACK,
    input  logic        TX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [7:0]  ERR_COUNT,
    output logic [7:0]  DROP_COUNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        CSUM = 2'd3
    } state_t;

    // Input synchroniser and change detection
    logic [79:0] s1_q;
    logic [79:0] s2_q;
    logic [79:0] last_seen_q;

    // Single-entry pending buffer and error/drop statistics
    logic [79:0] pend_q;
    logic        pend_vld_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  drop_cnt_q;

    // Transmit FSM state
    state_t      state_q;
    logic [79:0] shadow_q;
    logic [3:0]  byte_idx_q;
    logic [7:0]  csum_q;
    logic [7:0]  tx_data_q;
    logic        tx_vld_q;
    logic        busy_q;
    logic        frame_done_q;

    // Combinational helpers
    logic        new_stack_d;
    logic        fmt_ok_d;
    logic        accept_d;
    logic        reject_d;
    logic        load_d;
    logic        xfer_d;
    logic [3:0]  nxt_idx_d;
    logic [7:0]  nxt_byte_d;
    logic [7:0]  csum_d;

    // Two-flop synchroniser: the 80-bit bus is only trusted once both stages agree.
    always_ff @(posedge CLK_100KHZ) begin
        if (RESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= G_DATA_STACK;
            s2_q <= s1_q;
        end
    end

    // A stack is new when it is stable across both stages, differs from the last one seen and is non-zero.
    always_comb begin
        new_stack_d = (s1_q == s2_q) && (s2_q != last_seen_q) && (s2_q != '0);
        fmt_ok_d    = (s2_q[7:0] == GEIG_ID) && (s2_q[79:48] == FILLER);
        accept_d    = new_stack_d && fmt_ok_d;
        reject_d    = new_stack_d && !fmt_ok_d;
        // The FSM takes the pending stack on any IDLE cycle in which one is waiting.
        load_d      = (state_q == IDLE) && pend_vld_q;
        xfer_d      = tx_vld_q && TX_READY;
    end

    // Pending-slot management: accept/reject new stacks, count rejections and overwrites.
    always_ff @(posedge CLK_100KHZ) begin
        if (RESET) begin
            last_seen_q <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            // last_seen tracks rejected stacks too, so a static bad stack is counted once.
            if (new_stack_d) begin
                last_seen_q <= s2_q;
            end
            if (reject_d && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (accept_d) begin
                pend_q     <= s2_q;
                pend_vld_q <= 1'b1;
                // An acceptance in the same cycle the FSM drains the slot is not an overwrite.
                if (pend_vld_q && !load_d && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end else if (load_d) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    // Next body byte and the running checksum including the byte now on TX_DATA.
    always_comb begin
        nxt_idx_d  = byte_idx_q + 4'd1;
        nxt_byte_d = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (nxt_idx_d == 4'(k)) begin
                nxt_byte_d = shadow_q[8*k +: 8];
            end
        end
        csum_d = csum_q ^ tx_data_q;
    end

    // Frame FSM with registered outputs: SYNC, 10 body bytes LSB-first, XOR checksum.
    always_ff @(posedge CLK_100KHZ) begin
        if (RESET) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            tx_data_q    <= '0;
            tx_vld_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_vld_q) begin
                        // Shadow is only written here, so it stays frozen for the whole frame.
                        shadow_q   <= pend_q;
                        csum_q     <= '0;
                        byte_idx_q <= '0;
                        tx_data_q  <= SYNC_BYTE;
                        tx_vld_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= HDR;
                    end
                end
                HDR: begin
                    if (xfer_d) begin
                        byte_idx_q <= '0;
                        tx_data_q  <= shadow_q[7:0];
                        state_q    <= BODY;
                    end
                end
                BODY: begin
                    if (xfer_d) begin
                        csum_q <= csum_d;
                        if (byte_idx_q == 4'd9) begin
                            tx_data_q <= csum_d;
                            state_q   <= CSUM;
                        end else begin
                            byte_idx_q <= nxt_idx_d;
                            tx_data_q  <= nxt_byte_d;
                        end
                    end
                end
                CSUM: begin
                    if (xfer_d) begin
                        tx_data_q    <= '0;
                        tx_vld_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tx_vld_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign TX_DATA    = tx_data_q;
    assign TX_VALID   = tx_vld_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;
    assign ERR_COUNT  = err_cnt_q;
    assign DROP_COUNT = drop_cnt_q;

endmodule
